// File: rtl/march_pattern_gen_pkg.sv
// march_pattern_gen_pkg
// Shared definitions for the March C- pattern generator: default sizes,
// controller state encoding, element encoding and the per-element tables
// (sweep direction, op count, read/write data values).
package march_pattern_gen_pkg;

  localparam int unsigned DEF_ADDR_W   = 8;
  localparam int unsigned DEF_DATA_W   = 4;
  localparam int unsigned DEF_READ_LAT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 down(r0)
  typedef enum logic [2:0] {
    M0 = 3'd0,
    M1 = 3'd1,
    M2 = 3'd2,
    M3 = 3'd3,
    M4 = 3'd4,
    M5 = 3'd5
  } elem_e;

  // Tables are bit vectors indexed by the element number (bit 0 = M0).
  localparam logic [5:0] ELEM_DOWN       = 6'b111000;  // descending sweep
  localparam logic [5:0] ELEM_TWO_OPS    = 6'b011110;  // read then write at each address
  localparam logic [5:0] ELEM_FIRST_READ = 6'b111110;  // first op at an address is a read
  localparam logic [5:0] ELEM_RVAL       = 6'b010100;  // value expected by the read
  localparam logic [5:0] ELEM_WVAL       = 6'b001010;  // value written by the write

  function automatic logic elem_flag(input logic [5:0] tbl, input elem_e e);
    return tbl[e];
  endfunction

  function automatic elem_e next_elem(input elem_e e);
    return elem_e'(e + 3'd1);
  endfunction

endpackage

// File: rtl/march_pattern_gen_addr_seq.sv
// march_addr_seq
// Up/down SRAM address counter used by the March C- sequencer.
//   clk, rst_n       clock / async active-low reset
//   clear_i          force address to 0 (start of run)
//   load_i           load sweep start: all-ones when load_down_i, else 0
//   adv_i            step one address in the direction given by down_i
//   addr_o           current address
//   at_min_o/at_max_o  last-address flags for down/up sweeps
module march_addr_seq #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              load_down_i,
  input  logic              adv_i,
  input  logic              down_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              at_min_o,
  output logic              at_max_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (clear_i) begin
      addr_d = '0;
    end else if (load_i) begin
      addr_d = load_down_i ? '1 : '0;
    end else if (adv_i) begin
      addr_d = down_i ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o   = addr_q;
  assign at_min_o = (addr_q == '0);
  assign at_max_o = (addr_q == '1);

endmodule

// File: rtl/march_pattern_gen.sv
// march_pattern_gen
// March C- SRAM test pattern generator. Issues one operation per cycle,
// tracks reads through a READ_LAT-deep pipeline and records the first
// failing address reported by the external comparator.
//   clk, rst_n         clock / async active-low reset
//   start              one-cycle pulse, begins a run from IDLE or DONE
//   comp_fail          comparator mismatch, valid READ_LAT cycles after a read
//   addr, we, re       SRAM address and strobes
//   wdata, exp_data    write data / expected read data
//   comp_en_n          comparator enable (low = compare)
//   busy, done, fail   status; fail_addr holds the first failing address
// Build option: MARCH_STOP_ON_FAIL_EN stops issuing operations at the first
// detected failure and drains to DONE.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | after reset, waiting for start
// ST_RUN   | issuing March C- operations
// ST_DRAIN | no new ops, waiting READ_LAT cycles for in-flight reads
// ST_DONE  | run complete, status held until next start
module march_pattern_gen
  import march_pattern_gen_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned READ_LAT = DEF_READ_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              comp_fail,
  output logic [ADDR_W-1:0] addr,
  output logic              we,
  output logic              re,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] exp_data,
  output logic              comp_en_n,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr
);

  localparam int unsigned CNT_W = $clog2(READ_LAT + 1);
  localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(READ_LAT - 1);

  state_e            state_q, state_d;
  elem_e             elem_q, elem_d;
  logic              phase_q, phase_d;
  logic [CNT_W-1:0]  drain_q, drain_d;
  logic              fail_q, fail_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;

  logic [READ_LAT-1:0] rv_q;
  logic [ADDR_W-1:0]   ap_q [READ_LAT];

  logic              seq_clear, seq_load, seq_load_down, seq_adv;
  logic [ADDR_W-1:0] seq_addr;
  logic              seq_at_min, seq_at_max, seq_last;
  logic              op_last, op_read, fail_det, stop_now;

  march_addr_seq #(.ADDR_W(ADDR_W)) u_addr_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (seq_clear),
    .load_i      (seq_load),
    .load_down_i (seq_load_down),
    .adv_i       (seq_adv),
    .down_i      (elem_flag(ELEM_DOWN, elem_q)),
    .addr_o      (seq_addr),
    .at_min_o    (seq_at_min),
    .at_max_o    (seq_at_max)
  );

  assign seq_last = elem_flag(ELEM_DOWN, elem_q) ? seq_at_min : seq_at_max;
  // phase is 0 for the first op at an address, 1 for the second
  assign op_last  = (phase_q == elem_flag(ELEM_TWO_OPS, elem_q));
  assign op_read  = !phase_q && elem_flag(ELEM_FIRST_READ, elem_q);
  assign fail_det = rv_q[READ_LAT-1] && comp_fail;

`ifdef MARCH_STOP_ON_FAIL_EN
  // Detection suppresses the op in the same cycle so nothing follows it.
  assign stop_now = (state_q == ST_RUN) && fail_det;
`else
  assign stop_now = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    elem_d        = elem_q;
    phase_d       = phase_q;
    drain_d       = drain_q;
    fail_d        = fail_q;
    fail_addr_d   = fail_addr_q;
    seq_clear     = 1'b0;
    seq_load      = 1'b0;
    seq_load_down = 1'b0;
    seq_adv       = 1'b0;
    we            = 1'b0;
    re            = 1'b0;
    wdata         = '0;
    exp_data      = '0;

    if (fail_det && !fail_q) begin
      fail_d      = 1'b1;
      fail_addr_d = ap_q[READ_LAT-1];
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_RUN;
          elem_d      = M0;
          phase_d     = 1'b0;
          seq_clear   = 1'b1;
          fail_d      = 1'b0;
          fail_addr_d = '0;
        end
      end
      ST_RUN: begin
        if (stop_now) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_INIT;
        end else begin
          if (op_read) begin
            re       = 1'b1;
            exp_data = {DATA_W{elem_flag(ELEM_RVAL, elem_q)}};
          end else begin
            we    = 1'b1;
            wdata = {DATA_W{elem_flag(ELEM_WVAL, elem_q)}};
          end
          if (!op_last) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (!seq_last) begin
              seq_adv = 1'b1;
            end else if (elem_q == M5) begin
              state_d = ST_DRAIN;
              drain_d = DRAIN_INIT;
            end else begin
              // load the next sweep start in the same cycle: no idle slot at the wrap
              elem_d        = next_elem(elem_q);
              seq_load      = 1'b1;
              seq_load_down = elem_flag(ELEM_DOWN, next_elem(elem_q));
            end
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      elem_q      <= M0;
      phase_q     <= 1'b0;
      drain_q     <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      phase_q     <= phase_d;
      drain_q     <= drain_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv_q <= '0;
      for (int i = 0; i < READ_LAT; i++) ap_q[i] <= '0;
    end else begin
      rv_q[0] <= re;
      ap_q[0] <= seq_addr;
      for (int i = 1; i < READ_LAT; i++) begin
        rv_q[i] <= rv_q[i-1];
        ap_q[i] <= ap_q[i-1];
      end
    end
  end

  // Comparator is enabled in the cycle the SRAM data for a read is present.
  generate
    if (READ_LAT == 1) begin : g_cen_direct
      assign comp_en_n = !re;
    end else begin : g_cen_pipe
      assign comp_en_n = !rv_q[READ_LAT-2];
    end
  endgenerate

  assign addr      = seq_addr;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;

endmodule

// File: tb/tb_march_pattern_gen.sv
// Testbench for march_pattern_gen: SRAM + registered comparator model with an
// optional stuck-at cell, and an abstract March C- reference trace.
module tb_march_pattern_gen;

  localparam int AW = 8;
  localparam int DW = 4;
  localparam int RL = 2;
  localparam int N  = 1 << AW;
  localparam int TOTAL = 10 * N;

  logic          clk = 1'b0;
  logic          rst_n, start, comp_fail;
  logic [AW-1:0] addr, fail_addr;
  logic          we, re, comp_en_n, busy, done, fail;
  logic [DW-1:0] wdata, exp_data;

  always #5 clk = ~clk;

  march_pattern_gen #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .comp_fail(comp_fail),
    .addr(addr), .we(we), .re(re), .wdata(wdata), .exp_data(exp_data),
    .comp_en_n(comp_en_n), .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr)
  );

  // ---------------- SRAM + comparator model ----------------
  logic [DW-1:0] mem [N];
  logic [DW-1:0] rd_q, ex_q;
  bit f_en; int f_addr, f_bit; bit f_val;

  function automatic logic [DW-1:0] cell_read(input int a, input logic [DW-1:0] stored);
    logic [DW-1:0] d;
    d = stored;
    if (f_en && a == f_addr) d[f_bit] = f_val;
    return d;
  endfunction

  initial begin
    for (int i = 0; i < N; i++) mem[i] = '0;
    rd_q = '0; ex_q = '0; comp_fail = 1'b0;
  end

  always @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) begin
      rd_q <= cell_read(int'(addr), mem[addr]);
      ex_q <= exp_data;
    end
    if (!comp_en_n) comp_fail <= (rd_q != ex_q);
  end

  // ---------------- reference model ----------------
  typedef struct { bit rd; int a; bit v; } op_t;
  op_t tr[$];
  int m_nops, m_busy, m_fa;
  bit m_fail;
  logic [DW-1:0] mm [N];

  // ops: 0=w0 1=w1 2=r0 3=r1
  bit e_down [6] = '{0, 0, 0, 1, 1, 1};
  int e_n    [6] = '{1, 2, 2, 2, 2, 1};
  int e_op [6][2] = '{'{0, 0}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, 0}};

  task automatic build_model();
    int k_fail, a, code;
    bit v;
    logic [DW-1:0] val, d;
    tr.delete();
    k_fail = -1; m_fail = 0; m_fa = 0;
    for (int e = 0; e < 6; e++)
      for (int i = 0; i < N; i++) begin
        a = e_down[e] ? (N - 1 - i) : i;
        for (int k = 0; k < e_n[e]; k++) begin
          code = e_op[e][k];
          v = code[0];
          val = v ? {DW{1'b1}} : '0;
          if (code >= 2) begin
            d = cell_read(a, mm[a]);
            if (d != val && k_fail < 0) begin
              k_fail = tr.size(); m_fail = 1; m_fa = a;
            end
          end else begin
            mm[a] = val;
          end
          tr.push_back('{code >= 2, a, v});
        end
      end
    m_nops = TOTAL;
    m_busy = TOTAL + RL;
`ifdef MARCH_STOP_ON_FAIL_EN
    if (k_fail >= 0 && k_fail + RL <= TOTAL - 1) begin
      m_nops = k_fail + RL;
      m_busy = m_nops + RL + 1;
    end
`endif
  endtask

  // ---------------- checking ----------------
  int checks = 0, failures = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic run_march(input bit fe, input int fa, input int fb, input bit fv,
                           input int glitch_at, output bit got_fail, output int got_fa);
    int j, bad, first_bad, p;
    logic ew, er, ecen;
    logic [DW-1:0] ed;
    bit ok;
    f_en = fe; f_addr = fa; f_bit = fb; f_val = fv;
    build_model();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("start_clears_status", int'({busy, done, fail, fail_addr}), int'({1'b1, 1'b0, 1'b0, 8'h00}));
    j = 0; bad = 0; first_bad = -1;
    while (j < m_busy + 50) begin
      @(negedge clk);
      if (done) break;
      if (j == glitch_at) start = 1'b1;
      if (j == glitch_at + 1) start = 1'b0;
      ew = 0; er = 0; ed = '0;
      if (j < m_nops) begin
        er = tr[j].rd; ew = !tr[j].rd;
        ed = tr[j].v ? {DW{1'b1}} : '0;
      end
      p = j - (RL - 1);
      ecen = !(p >= 0 && p < m_nops && tr[p].rd);
      ok = (we === ew) && (re === er) && (comp_en_n === ecen) && (busy === 1'b1);
      if (ew && (wdata !== ed || addr !== AW'(tr[j].a))) ok = 0;
      if (er && (exp_data !== ed || addr !== AW'(tr[j].a))) ok = 0;
      if (!ok) begin
        bad++;
        if (first_bad < 0) first_bad = j;
      end
      j++;
    end
    start = 1'b0;
    if (first_bad >= 0) $display("  first divergent cycle %0d", first_bad);
    chk("done_reached", int'(done), 1);
    chk("busy_cycles", j, m_busy);
    chk("op_trace_bad_cycles", bad, 0);
    chk("busy_low_in_done", int'(busy), 0);
    chk("fail_vs_model", int'(fail), int'(m_fail));
    chk("fail_addr_vs_model", int'(fail_addr), m_fa);
    got_fail = fail; got_fa = int'(fail_addr);
  endtask

  typedef struct { bit fe; int fa; int fb; bit fv; int glitch; bit x_fail; int x_fa; } vec_t;
  vec_t vt [6];

  initial begin
    bit gf; int ga;
    vt[0] = '{0, 0,    0, 0, -1,  0, 0};     // fault-free
    vt[1] = '{1, 'h5A, 2, 0, -1,  1, 'h5A};  // SA0 bit2, caught by M2 r1
    vt[2] = '{1, 'h10, 1, 1, -1,  1, 'h10};  // SA1 bit1, caught by M1 r0
    vt[3] = '{1, 'hFF, 3, 0, -1,  1, 'hFF};  // SA0 at top address
    vt[4] = '{0, 0,    0, 0, 500, 0, 0};     // start pulse mid-run ignored
    vt[5] = '{1, 'h00, 0, 1, 37,  1, 'h00};  // SA1 at address 0

    rst_n = 1'b0; start = 1'b0; f_en = 0; f_addr = 0; f_bit = 0; f_val = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        int'({addr, we, re, wdata, exp_data, comp_en_n, busy, done, fail, fail_addr}),
        int'({8'h00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_waits_for_start", int'({busy, done, we, re}), 0);

    for (int i = 0; i < 6; i++) begin
      run_march(vt[i].fe, vt[i].fa, vt[i].fb, vt[i].fv, vt[i].glitch, gf, ga);
      chk($sformatf("vec%0d_fail", i), int'(gf), int'(vt[i].x_fail));
      chk($sformatf("vec%0d_fail_addr", i), ga, vt[i].x_fa);
    end

    for (int r = 0; r < 3; r++) begin
      run_march(bit'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
                int'($urandom_range(0, DW - 1)), bit'($urandom_range(0, 1)),
                int'($urandom_range(0, 2500)), gf, ga);
    end

    // reset asserted mid-run at operation 1000
    f_en = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (1001) @(negedge clk);
    chk("busy_before_midrun_reset", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_outputs",
        int'({addr, we, re, wdata, exp_data, comp_en_n, busy, done, fail, fail_addr}),
        int'({8'h00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_reset_idle", int'({busy, done, we, re}), 0);
    run_march(1, 'h5A, 2, 0, -1, gf, ga);
    chk("post_reset_run_fail_addr", ga, 'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
